// File: rtl/inta_sequencer.sv
//==============================================================
// Module  : inta_sequencer
// Purpose : 8259-style INTA sequencer; raises INT, runs the
//           acknowledge pulses, drives the vector, owns the ISR.
// Option  : AUTO_EOI_EN adds aeoi_mode (auto EOI on final rise).
// Rev     : 1.0
//==============================================================
`default_nettype none

module inta_sequencer #(
  parameter int         INTA_PULSES    = 2,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chosen_interrupt,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
`ifdef AUTO_EOI_EN
  input  logic       aeoi_mode,
`endif
  output logic       int_out,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] in_service,
  output logic [7:0] clear_irr,
  output logic       spurious
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic       prev_inta;
  logic       armed;
  logic [2:0] level, level_nx;
  logic       int_nx, oe_nx, spur_nx;
  logic [7:0] dout_nx, isr_nx, clr_nx;
`ifdef AUTO_EOI_EN
  logic       level_valid, level_valid_nx;
`endif

  logic       fall, rise, has_req, eligible;
  logic [2:0] pend_level;
  logic [7:0] isr_lowest;

  // armed blocks a low inta_n that survived reset from counting as a fall
  assign fall       = prev_inta & ~inta_n & armed;
  assign rise       = ~prev_inta & inta_n;
  assign has_req    = |chosen_interrupt;
  assign isr_lowest = in_service & (~in_service + 8'd1);
  // mask of all levels above the highest in-service one (all ones when ISR empty)
  assign eligible   = |(chosen_interrupt & (isr_lowest - 8'd1));

  always_comb begin
    pend_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (chosen_interrupt[i]) pend_level = i[2:0];
    end
  end

  always_comb begin
    state_nx = state;
    level_nx = level;
    int_nx   = int_out;
    oe_nx    = data_oe;
    dout_nx  = data_out;
    clr_nx   = 8'h00;
    spur_nx  = 1'b0;
    isr_nx   = in_service;
`ifdef AUTO_EOI_EN
    level_valid_nx = level_valid;
`endif

    // EOI clear first so an acknowledge set of the same bit wins
    if (eoi_cmd) begin
      if (eoi_specific) isr_nx[eoi_level] = 1'b0;
      else              isr_nx = in_service & (in_service - 8'd1);
    end

    case (state)
      IDLE: begin
        int_nx = eligible;
        if (fall) begin
          int_nx = 1'b0;
          if (has_req) begin
            level_nx           = pend_level;
            isr_nx[pend_level] = 1'b1;
            clr_nx             = 8'd1 << pend_level;
          end else begin
            level_nx = SPURIOUS_LEVEL;
            spur_nx  = 1'b1;
          end
`ifdef AUTO_EOI_EN
          level_valid_nx = has_req;
`endif
          if (INTA_PULSES == 2) begin
            state_nx = ACK1;
          end else begin
            state_nx = ACK2;
            oe_nx    = 1'b1;
            dout_nx  = {vector_base, level_nx};
          end
        end
      end
      ACK1: begin
        int_nx = 1'b0;
        oe_nx  = 1'b0;
        if (rise) state_nx = WAIT2;
      end
      WAIT2: begin
        int_nx = 1'b0;
        if (fall) begin
          state_nx = ACK2;
          oe_nx    = 1'b1;
          dout_nx  = {vector_base, level};
        end
      end
      ACK2: begin
        int_nx  = 1'b0;
        oe_nx   = 1'b1;
        dout_nx = {vector_base, level};
        if (rise) begin
          oe_nx    = 1'b0;
          state_nx = IDLE;
`ifdef AUTO_EOI_EN
          if (aeoi_mode && level_valid) isr_nx[level] = 1'b0;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev_inta  <= 1'b1;
      armed      <= 1'b0;
      level      <= 3'd0;
      int_out    <= 1'b0;
      data_oe    <= 1'b0;
      data_out   <= 8'h00;
      in_service <= 8'h00;
      clear_irr  <= 8'h00;
      spurious   <= 1'b0;
`ifdef AUTO_EOI_EN
      level_valid <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      prev_inta  <= inta_n;
      armed      <= armed | inta_n;
      level      <= level_nx;
      int_out    <= int_nx;
      data_oe    <= oe_nx;
      data_out   <= dout_nx;
      in_service <= isr_nx;
      clear_irr  <= clr_nx;
      spurious   <= spur_nx;
`ifdef AUTO_EOI_EN
      level_valid <= level_valid_nx;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inta_sequencer.sv
//==============================================================
// Module  : tb_inta_sequencer
// Purpose : Self-checking bench for inta_sequencer (vectors,
//           corner sequences, random run against a pulse model).
// Rev     : 1.0
//==============================================================
`default_nettype none

module tb_inta_sequencer;

  localparam int PULSES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chosen_interrupt;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       eoi_cmd, eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out, data_oe, spurious;
  logic [7:0] data_out, in_service, clear_irr;
`ifdef AUTO_EOI_EN
  logic       aeoi_mode;
`endif

  int total = 0;
  int bad   = 0;

  inta_sequencer #(.INTA_PULSES(PULSES), .SPURIOUS_LEVEL(3'd7)) dut (
    .clk(clk), .reset(reset), .chosen_interrupt(chosen_interrupt), .inta_n(inta_n),
    .vector_base(vector_base), .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level),
`ifdef AUTO_EOI_EN
    .aeoi_mode(aeoi_mode),
`endif
    .int_out(int_out), .data_out(data_out), .data_oe(data_oe),
    .in_service(in_service), .clear_irr(clear_irr), .spurious(spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inta;
    logic [7:0] chosen;
    logic       eoi;
    logic       spec;
    logic [2:0] lvl;
    logic       e_int;
    logic       e_oe;
    logic [7:0] e_dout;
    logic [7:0] e_isr;
    logic [7:0] e_clr;
    logic       e_sp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic inta, input logic [7:0] chosen, input logic eoi,
                     input logic spec, input logic [2:0] lvl, input logic e_int,
                     input logic e_oe, input logic [7:0] e_dout, input logic [7:0] e_isr,
                     input logic [7:0] e_clr, input logic e_sp);
    vec_t v;
    v = '{inta, chosen, eoi, spec, lvl, e_int, e_oe, e_dout, e_isr, e_clr, e_sp};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_int, input logic e_oe,
                            input logic [7:0] e_dout, input logic [7:0] e_isr,
                            input logic [7:0] e_clr, input logic e_sp);
    chk({tag, ".int_out"}, {31'd0, int_out}, {31'd0, e_int});
    chk({tag, ".data_oe"}, {31'd0, data_oe}, {31'd0, e_oe});
    if (e_oe) chk({tag, ".data_out"}, {24'd0, data_out}, {24'd0, e_dout});
    chk({tag, ".in_service"}, {24'd0, in_service}, {24'd0, e_isr});
    chk({tag, ".clear_irr"}, {24'd0, clear_irr}, {24'd0, e_clr});
    chk({tag, ".spurious"}, {31'd0, spurious}, {31'd0, e_sp});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counts acknowledge pulses instead of tracking states
  logic       m_prev, m_armed, m_busy, m_real;
  int         m_falls, m_rises;
  logic [2:0] m_level;
  logic       m_int, m_oe, m_sp;
  logic [7:0] m_dout, m_isr, m_clr;

  task automatic model_reset();
    m_prev = 1'b1; m_armed = 1'b0; m_busy = 1'b0; m_real = 1'b0;
    m_falls = 0; m_rises = 0; m_level = 3'd0;
    m_int = 1'b0; m_oe = 1'b0; m_sp = 1'b0;
    m_dout = 8'h00; m_isr = 8'h00; m_clr = 8'h00;
  endtask

  task automatic model_step();
    logic       f, r, elig;
    logic [7:0] isr_n;
    int         p, lo;
    if (reset) begin
      model_reset();
      return;
    end
    f = m_prev && !inta_n && m_armed;
    r = !m_prev && inta_n;
    m_armed = m_armed | inta_n;
    m_prev  = inta_n;
    p  = -1;
    lo = 8;
    for (int i = 7; i >= 0; i--) begin
      if (chosen_interrupt[i]) p = i;
      if (m_isr[i]) lo = i;
    end
    elig  = (p >= 0) && (p < lo);
    isr_n = m_isr;
    if (eoi_cmd) begin
      if (eoi_specific) isr_n[eoi_level] = 1'b0;
      else if (lo < 8)  isr_n[lo] = 1'b0;
    end
    m_clr = 8'h00;
    m_sp  = 1'b0;
    if (!m_busy) begin
      m_int = elig;
      if (f) begin
        m_busy = 1'b1; m_falls = 1; m_rises = 0; m_int = 1'b0;
        if (p >= 0) begin
          m_level = p[2:0]; m_real = 1'b1; isr_n[p] = 1'b1; m_clr[p] = 1'b1;
        end else begin
          m_level = 3'd7; m_real = 1'b0; m_sp = 1'b1;
        end
      end
    end else begin
      m_int = 1'b0;
      if (f && m_falls == m_rises && m_falls < PULSES) m_falls++;
      else if (r && m_rises < m_falls) begin
        m_rises++;
        if (m_rises == PULSES) begin
          m_busy = 1'b0;
`ifdef AUTO_EOI_EN
          if (aeoi_mode && m_real) isr_n[m_level] = 1'b0;
`endif
        end
      end
    end
    m_oe = m_busy && (m_falls == PULSES) && (m_rises < m_falls);
    if (m_oe) m_dout = {vector_base, m_level};
    m_isr = isr_n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold;
    reset = 1'b1; inta_n = 1'b1; chosen_interrupt = 8'h00; vector_base = 5'h11;
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
`ifdef AUTO_EOI_EN
    aeoi_mode = 1'b0;
`endif
    #1;
    chk("reset.data_out", {24'd0, data_out}, 32'h0);
    check_outs("reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle();

    // inta, chosen, eoi, spec, lvl | int, oe, dout, isr, clr, spurious
    add(1, 8'h08, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h08, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h08, 0);
    add(0, 8'h08, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 0);
    add(0, 8'h00, 0, 0, 0,  0, 1, 8'h8B, 8'h08, 8'h00, 0);
    add(0, 8'h00, 0, 0, 0,  0, 1, 8'h8B, 8'h08, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 0);
    add(1, 8'h20, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 0);
    add(1, 8'h20, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 0);
    add(1, 8'h02, 0, 0, 0,  1, 0, 8'h00, 8'h08, 8'h00, 0);
    add(0, 8'h02, 0, 0, 0,  0, 0, 8'h00, 8'h0A, 8'h02, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h0A, 8'h00, 0);
    add(0, 8'h00, 0, 0, 0,  0, 1, 8'h89, 8'h0A, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h0A, 8'h00, 0);
    add(1, 8'h00, 1, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00, 0);
    add(1, 8'h00, 1, 1, 3,  0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 1, 1, 5,  0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 1);
    add(0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 0, 0, 0,  0, 1, 8'h8F, 8'h00, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h04, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h04, 1, 1, 2,  0, 0, 8'h00, 8'h04, 8'h04, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h04, 8'h00, 0);
    add(0, 8'h00, 0, 0, 0,  0, 1, 8'h8A, 8'h04, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 8'h04, 8'h00, 0);
    add(1, 8'h00, 1, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      inta_n = tbl[i].inta; chosen_interrupt = tbl[i].chosen;
      eoi_cmd = tbl[i].eoi; eoi_specific = tbl[i].spec; eoi_level = tbl[i].lvl;
      cycle();
      check_outs($sformatf("vec%0d", i), tbl[i].e_int, tbl[i].e_oe, tbl[i].e_dout,
                 tbl[i].e_isr, tbl[i].e_clr, tbl[i].e_sp);
    end
    eoi_cmd = 1'b0;

    // reset during the vector pulse, then release with inta_n still low
    chosen_interrupt = 8'h01; inta_n = 1'b1; cycle();
    inta_n = 1'b0; cycle();
    inta_n = 1'b1; cycle();
    inta_n = 1'b0; cycle();
    chk("rstack.pre_oe", {31'd0, data_oe}, 32'd1);
    chk("rstack.pre_isr", {24'd0, in_service}, 32'h01);
    reset = 1'b1;
    #1;
    chk("rstack.oe", {31'd0, data_oe}, 32'd0);
    chk("rstack.isr", {24'd0, in_service}, 32'h00);
    chk("rstack.int", {31'd0, int_out}, 32'd0);
    cycle(); cycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("rstlow%0d.oe", k), {31'd0, data_oe}, 32'd0);
      chk($sformatf("rstlow%0d.isr", k), {24'd0, in_service}, 32'h00);
    end
    inta_n = 1'b1; cycle();
    inta_n = 1'b0; cycle();
    chk("rstnew.isr", {24'd0, in_service}, 32'h01);
    chk("rstnew.clr", {24'd0, clear_irr}, 32'h01);
    inta_n = 1'b1; chosen_interrupt = 8'h00; cycle();
    inta_n = 1'b0; cycle();
    chk("rstnew.oe", {31'd0, data_oe}, 32'd1);
    chk("rstnew.dout", {24'd0, data_out}, 32'h88);
    inta_n = 1'b1; cycle();
    eoi_cmd = 1'b1; eoi_specific = 1'b0; cycle();
    eoi_cmd = 1'b0;
    chk("rstnew.eoi", {24'd0, in_service}, 32'h00);

`ifdef AUTO_EOI_EN
    aeoi_mode = 1'b1; chosen_interrupt = 8'h01; cycle();
    inta_n = 1'b0; cycle();
    chk("aeoi.isr1", {24'd0, in_service}, 32'h01);
    inta_n = 1'b1; chosen_interrupt = 8'h00; cycle();
    inta_n = 1'b0; cycle();
    chk("aeoi.isr2", {24'd0, in_service}, 32'h01);
    inta_n = 1'b1; cycle();
    chk("aeoi.isr_end", {24'd0, in_service}, 32'h00);
    aeoi_mode = 1'b0;
`endif

    // randomized run against the pulse-counting model
    reset = 1'b1;
    model_reset();
    hold = 0;
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outs($sformatf("rand%0d", n), m_int, m_oe, m_dout, m_isr, m_clr, m_sp);
      reset = (n > 2) && ($urandom_range(0, 249) == 0);
      if (hold == 0) begin
        inta_n = ~inta_n;
        hold = inta_n ? $urandom_range(0, 5) : $urandom_range(0, 3);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 3) == 0)
        chosen_interrupt = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'd1 << $urandom_range(0, 7));
      eoi_cmd = ($urandom_range(0, 7) == 0);
      eoi_specific = 1'($urandom);
      eoi_level = 3'($urandom);
      if ($urandom_range(0, 31) == 0) vector_base = 5'($urandom);
`ifdef AUTO_EOI_EN
      if ($urandom_range(0, 15) == 0) aeoi_mode = 1'($urandom);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Sits directly downstream of the priority resolver in the 8259-style PIC.
- Consumes the resolver's one-hot `chosen_interrupt` and asserts the interrupt line to the CPU.
- Sequences the INTA acknowledge cycles and places the vector byte on the data bus.
- Owns the registered in-service register (ISR), which is set on acknowledge and cleared by EOI commands.

Parameters:
- INTA_PULSES, 2, acknowledge pulses per cycle: 2 = 8086 mode (no data on first pulse, vector on second); 1 = vector on the only pulse.
- SPURIOUS_LEVEL, 7, level reported when the first pulse finds no request.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- chosen_interrupt  input  8  one-hot from the priority resolver; 0 means no request.
- inta_n  input  1  CPU acknowledge strobe, active-low, already synchronised to clk.
- vector_base  input  5  vector bits T7..T3 from the control registers.
- eoi_cmd  input  1  one-cycle EOI command pulse.
- eoi_specific  input  1  qualifies eoi_cmd: 1 = specific, 0 = non-specific.
- eoi_level  input  3  bit to clear on a specific EOI.
- int_out  output  1  interrupt request to the CPU.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.
- in_service  output  8  ISR contents.
- clear_irr  output  8  one-cycle pulse to the IRR stage to drop an accepted edge request.
- spurious  output  1  one-cycle pulse when an acknowledge finds no request.

Behaviour:
- Reset values: state=IDLE; int_out, data_out, data_oe, in_service, clear_irr and spurious all 0; frozen level 0; prev_inta=1.
- Edge detection: fall = prev_inta & ~inta_n; rise = ~prev_inta & inta_n. prev_inta is registered every cycle.
- Pending level p = index of the single set bit of chosen_interrupt.
- Nesting rule: eligible = chosen_interrupt≠0 and (in_service==0 or p < lowest set index of in_service). Lower index is higher priority.
- IDLE, int_out: int_out <= eligible, registered, so 1-cycle latency.
- IDLE, on fall:
  - Freeze the level: p if chosen_interrupt≠0, else SPURIOUS_LEVEL.
  - If a request exists: set in_service[p] and pulse clear_irr[p].
  - If none: in_service is unchanged and spurious is pulsed.
  - int_out <= 0.
  - Next state: ACK1 if INTA_PULSES==2, else ACK2.
- ACK1: data_oe=0. On rise -> WAIT2.
- WAIT2: on fall -> ACK2.
- ACK2: data_oe=1 and data_out={vector_base, frozen_level} from the cycle after the fall. On rise: data_oe <= 0 and state -> IDLE.
- Changes to chosen_interrupt after the first fall do not alter the frozen level.
- A fall in any non-IDLE state other than WAIT2 is ignored.
- Non-specific EOI (eoi_cmd & ~eoi_specific): clear the lowest set bit of in_service; no effect when in_service is 0.
- Specific EOI (eoi_cmd & eoi_specific): clear in_service[eoi_level]; no effect if that bit is already 0.
- EOI is accepted in any state. In the same cycle the EOI clear is applied first, then the acknowledge set, so a set of the same bit wins.
- Only one ISR bit is set per acknowledge cycle.
- Reset asserted mid-sequence: immediately data_oe=0, int_out=0, in_service=0. After reset deasserts, wait in IDLE for a fresh fall; any inta_n already low is not treated as a fall until it rises and falls again.

Optional Feature:
- Macro AUTO_EOI_EN.
- Defined: adds input port aeoi_mode (1 bit). When aeoi_mode=1, the in_service bit set by the current acknowledge is cleared on the rise that ends ACK2. in_service pulses high only during the acknowledge. eoi_cmd still functions.
- Undefined: the port is absent; ISR bits are cleared only by EOI commands.

Test Plan:
- Basic 8086 ack: chosen=8'h08, vector_base=5'h11 -> int_out=1 one cycle later. First INTA low -> in_service=8'h08, clear_irr=8'h08 for 1 cycle, int_out=0. Second INTA -> data_oe=1, data_out=8'h8B. Release -> data_oe=0.
- Nesting: in_service=8'h08; chosen=8'h20 -> int_out stays 0. chosen=8'h02 -> int_out=1; after ack, in_service=8'h0A.
- EOI: in_service=8'h0A, non-specific EOI -> 8'h08. Specific EOI with level 3 -> 8'h00. Specific EOI with level 5 on an empty ISR -> stays 8'h00.
- Spurious: chosen=0, INTA pair -> spurious pulses once, in_service unchanged, data_out={vector_base,3'd7}.
- Reset mid-ack: assert reset during ACK2 -> data_oe and in_service drop to 0 immediately. After release with inta_n held low, no data_oe until a new low pulse.
- AUTO_EOI_EN with aeoi_mode=1: ack of chosen=8'h01 -> in_service=8'h01 during the ack, returns to 8'h00 on the final rise.
